// File: rtl/q_tile_ring_buffer_pkg.sv
// Shared Q-buffer types: Q vector, full tile and ring-buffer defaults.
`ifndef NUM_PES
`define NUM_PES 4
`endif

package q_tile_ring_buffer_pkg;

  localparam int Q_VECTOR_W         = 32;
  localparam int NUM_PES            = `NUM_PES;
  localparam int QBUF_BANKS_DEFAULT = 3;

  typedef logic [Q_VECTOR_W-1:0] Q_VECTOR_T;
  typedef Q_VECTOR_T q_tile_t [NUM_PES];

  // Ring pointer increment with explicit wrap, valid for any ring size.
  function automatic int unsigned ring_next(input int unsigned ptr, input int unsigned size);
    if (ptr >= size - 32'd1) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/q_ring_ctrl.sv
// Ring control for the Q tile buffer: fill/drain pointers, per-bank full flags,
// row counts and occupancy; drives bank write enables and the read bank select.
module q_ring_ctrl
  import q_tile_ring_buffer_pkg::*;
#(
  parameter  int NUM_ROWS  = 4,
  parameter  int NUM_BANKS = 3,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int ROW_W     = $clog2(NUM_ROWS),
  localparam int CNT_W     = $clog2(NUM_ROWS + 1),
  localparam int OCC_W     = $clog2(NUM_BANKS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 wr_valid_i,
  input  logic                 wr_last_i,
  input  logic                 rd_release_i,
  output logic                 wr_ready_o,
  output logic                 rd_valid_o,
  output logic [NUM_BANKS-1:0] bank_wr_en_o,
  output logic [ROW_W-1:0]     wr_idx_o,
  output logic [BANK_W-1:0]    rd_bank_o,
  output logic [CNT_W-1:0]     rd_row_cnt_o,
  output logic [OCC_W-1:0]     occupancy_o
);

  logic [BANK_W-1:0]    wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0]    rd_bank_q, rd_bank_d;
  logic [ROW_W-1:0]     wr_idx_q, wr_idx_d;
  logic [NUM_BANKS-1:0] full_q, full_d;
  logic [CNT_W-1:0]     row_cnt_q [NUM_BANKS];
  logic [CNT_W-1:0]     row_cnt_d [NUM_BANKS];
  logic [OCC_W-1:0]     occ_q, occ_d;

  logic accept_s;
  logic close_s;
  logic release_s;

  assign wr_ready_o   = ~full_q[wr_bank_q];
  assign rd_valid_o   = full_q[rd_bank_q];
  assign wr_idx_o     = wr_idx_q;
  assign rd_bank_o    = rd_bank_q;
  assign rd_row_cnt_o = row_cnt_q[rd_bank_q];
  assign occupancy_o  = occ_q;

  // Next-state: flush wins over any same-cycle write or release.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    full_d    = full_q;
    row_cnt_d = row_cnt_q;
    occ_d     = occ_q;
    accept_s  = wr_valid_i & ~full_q[wr_bank_q] & ~flush_i;
    close_s   = accept_s & (wr_last_i | (wr_idx_q == ROW_W'(NUM_ROWS - 1)));
    release_s = rd_release_i & full_q[rd_bank_q] & ~flush_i;

    if (flush_i) begin
      wr_bank_d = '0;
      rd_bank_d = '0;
      wr_idx_d  = '0;
      full_d    = '0;
      occ_d     = '0;
    end else begin
      if (close_s) begin
        full_d[wr_bank_q]    = 1'b1;
        row_cnt_d[wr_bank_q] = CNT_W'(wr_idx_q) + CNT_W'(1);
        wr_bank_d            = BANK_W'(ring_next(32'(wr_bank_q), NUM_BANKS));
        wr_idx_d             = '0;
      end else if (accept_s) begin
        wr_idx_d = wr_idx_q + ROW_W'(1);
      end else begin
        wr_idx_d = wr_idx_q;
      end

      if (release_s) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = BANK_W'(ring_next(32'(rd_bank_q), NUM_BANKS));
      end else begin
        rd_bank_d = rd_bank_q;
      end

      case ({close_s, release_s})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // One-hot storage write strobe for the bank being filled.
  always_comb begin
    bank_wr_en_o = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (accept_s && !rst && (wr_bank_q == BANK_W'(b))) begin
        bank_wr_en_o[b] = 1'b1;
      end else begin
        bank_wr_en_o[b] = 1'b0;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      wr_idx_q  <= '0;
      full_q    <= '0;
      occ_q     <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        row_cnt_q[b] <= '0;
      end
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      full_q    <= full_d;
      occ_q     <= occ_d;
      row_cnt_q <= row_cnt_d;
    end
  end

endmodule

// File: rtl/q_tile_ring_buffer.sv
// N-bank Q tile ring buffer: row-per-beat fill from the memory controller,
// whole oldest tile presented to the PEs with a per-row valid mask.
module q_tile_ring_buffer
  import q_tile_ring_buffer_pkg::*;
#(
  parameter  int NUM_ROWS  = `NUM_PES,
  parameter  int NUM_BANKS = QBUF_BANKS_DEFAULT,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int ROW_W     = $clog2(NUM_ROWS),
  localparam int CNT_W     = $clog2(NUM_ROWS + 1),
  localparam int OCC_W     = $clog2(NUM_BANKS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  Q_VECTOR_T           wr_data_i,
  input  logic                wr_last_i,
  output logic                rd_valid_o,
  input  logic                rd_release_i,
  output Q_VECTOR_T           rd_data_o [NUM_ROWS],
  output logic [NUM_ROWS-1:0] rd_row_mask_o,
  output logic [OCC_W-1:0]    occupancy_o
);

  logic [NUM_BANKS-1:0] bank_wr_en_s;
  logic [ROW_W-1:0]     wr_idx_s;
  logic [BANK_W-1:0]    rd_bank_s;
  logic [CNT_W-1:0]     rd_row_cnt_s;

  // Storage is deliberately not reset; the mask hides stale rows.
  Q_VECTOR_T bank_q [NUM_BANKS][NUM_ROWS];

  q_ring_ctrl #(
    .NUM_ROWS  (NUM_ROWS),
    .NUM_BANKS (NUM_BANKS)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .wr_valid_i   (wr_valid_i),
    .wr_last_i    (wr_last_i),
    .rd_release_i (rd_release_i),
    .wr_ready_o   (wr_ready_o),
    .rd_valid_o   (rd_valid_o),
    .bank_wr_en_o (bank_wr_en_s),
    .wr_idx_o     (wr_idx_s),
    .rd_bank_o    (rd_bank_s),
    .rd_row_cnt_o (rd_row_cnt_s),
    .occupancy_o  (occupancy_o)
  );

  // Row storage write port.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_wr_en_s[b]) begin
        bank_q[b][wr_idx_s] <= wr_data_i;
      end
    end
  end

  // Parallel tile presentation, zeroing rows beyond the tile's row count.
  always_comb begin
    rd_row_mask_o = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (rd_valid_o && (CNT_W'(r) < rd_row_cnt_s)) begin
        rd_row_mask_o[r] = 1'b1;
        rd_data_o[r]     = bank_q[rd_bank_s][r];
      end else begin
        rd_row_mask_o[r] = 1'b0;
        rd_data_o[r]     = '0;
      end
    end
  end

endmodule

// File: tb/tb_q_tile_ring_buffer.sv
// Directed table-driven bench for q_tile_ring_buffer (4 rows, 3 banks).
module tb_q_tile_ring_buffer;
  import q_tile_ring_buffer_pkg::*;

  localparam int NR = 4;
  localparam int NB = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            wr_valid;
  logic            wr_ready;
  Q_VECTOR_T       wr_data;
  logic            wr_last;
  logic            rd_valid;
  logic            rd_release;
  Q_VECTOR_T       rd_data [NR];
  logic [NR-1:0]   rd_row_mask;
  logic [1:0]      occupancy;

  int checks = 0;
  int errors = 0;

  q_tile_ring_buffer #(.NUM_ROWS(NR), .NUM_BANKS(NB)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .wr_data_i     (wr_data),
    .wr_last_i     (wr_last),
    .rd_valid_o    (rd_valid),
    .rd_release_i  (rd_release),
    .rd_data_o     (rd_data),
    .rd_row_mask_o (rd_row_mask),
    .occupancy_o   (occupancy)
  );

  always #5 clk = ~clk;

  typedef logic [NR-1:0][31:0] tile_t;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        last;
    logic        rel;
    logic        fl;
    logic        e_ready;
    logic        e_rv;
    logic [3:0]  e_mask;
    logic [1:0]  e_occ;
    tile_t       e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] q(input logic [7:0] tag, input int r);
    return {tag, 24'(r)};
  endfunction

  function automatic tile_t tile(input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] d3);
    tile_t t;
    t[0] = d0; t[1] = d1; t[2] = d2; t[3] = d3;
    return t;
  endfunction

  function automatic tile_t full4(input logic [7:0] tag);
    return tile(q(tag, 0), q(tag, 1), q(tag, 2), q(tag, 3));
  endfunction

  function automatic void add(input logic v, input logic [31:0] d, input logic last,
                              input logic rel, input logic fl, input logic e_ready,
                              input logic e_rv, input logic [3:0] e_mask,
                              input logic [1:0] e_occ, input tile_t e_data);
    vec_t x;
    x.v = v; x.d = d; x.last = last; x.rel = rel; x.fl = fl;
    x.e_ready = e_ready; x.e_rv = e_rv; x.e_mask = e_mask; x.e_occ = e_occ;
    x.e_data = e_data;
    vecs.push_back(x);
  endfunction

  function automatic tile_t got_tile();
    tile_t t;
    for (int r = 0; r < NR; r++) t[r] = rd_data[r];
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_ready, input logic e_rv,
                           input logic [3:0] e_mask, input logic [1:0] e_occ,
                           input tile_t e_data);
    check({tag, "_wr_ready"}, 128'(wr_ready), 128'(e_ready));
    check({tag, "_rd_valid"}, 128'(rd_valid), 128'(e_rv));
    check({tag, "_mask"}, 128'(rd_row_mask), 128'(e_mask));
    check({tag, "_occ"}, 128'(occupancy), 128'(e_occ));
    check({tag, "_data"}, 128'(got_tile()), 128'(e_data));
  endtask

  tile_t z;
  int    k;

  initial begin
    z = '0;
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
    wr_last = 1'b0; rd_release = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b1, 1'b0, 4'h0, 2'd0, z);
    rst = 1'b0;

    // Full tile A into bank0, then fill B, C until the ring is full.
    for (int r = 0; r < 3; r++) add(1'b1, q(8'hA0, r), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, z);
    add(1'b1, q(8'hA0, 3), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 2'd1, full4(8'hA0));
    for (int r = 0; r < 3; r++) add(1'b1, q(8'hB0, r), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 2'd1, full4(8'hA0));
    add(1'b1, q(8'hB0, 3), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 2'd2, full4(8'hA0));
    for (int r = 0; r < 3; r++) add(1'b1, q(8'hC0, r), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 2'd2, full4(8'hA0));
    add(1'b1, q(8'hC0, 3), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 2'd3, full4(8'hA0));
    // 13th beat held, then release frees bank0.
    add(1'b1, q(8'hD0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 2'd3, full4(8'hA0));
    add(1'b1, q(8'hD0, 0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 2'd2, full4(8'hB0));
    add(1'b1, q(8'hD0, 0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 2'd2, full4(8'hB0));
    add(1'b1, q(8'hD0, 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 2'd3, full4(8'hB0));
    add(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 2'd2, full4(8'hC0));
    add(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 2'd1, tile(q(8'hD0, 0), q(8'hD0, 1), 32'h0, 32'h0));
    // Close and release in the same cycle.
    add(1'b1, q(8'hE0, 0), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 2'd1, tile(q(8'hE0, 0), 32'h0, 32'h0, 32'h0));
    // Flush mid-fill with a concurrent write and release.
    add(1'b1, q(8'hF0, 0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 2'd1, tile(q(8'hE0, 0), 32'h0, 32'h0, 32'h0));
    add(1'b1, q(8'hF0, 1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 2'd1, tile(q(8'hE0, 0), 32'h0, 32'h0, 32'h0));
    add(1'b1, q(8'hF0, 2), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0, z);
    add(1'b1, q(8'h60, 0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, z);
    add(1'b1, q(8'h60, 1), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 2'd1, tile(q(8'h60, 0), q(8'h60, 1), 32'h0, 32'h0));
    // Release, then release while empty is ignored.
    add(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, z);
    add(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, z);
    // wr_last on the final row behaves as a normal close.
    for (int r = 0; r < 3; r++) add(1'b1, q(8'h70, r), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, z);
    add(1'b1, q(8'h70, 3), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 2'd1, full4(8'h70));
    add(1'b1, q(8'h80, 0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 2'd2, full4(8'h70));
    add(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 2'd1, tile(q(8'h80, 0), 32'h0, 32'h0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      wr_valid = vecs[i].v; wr_data = vecs[i].d; wr_last = vecs[i].last;
      rd_release = vecs[i].rel; flush = vecs[i].fl;
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].e_ready, vecs[i].e_rv, vecs[i].e_mask,
                vecs[i].e_occ, vecs[i].e_data);
    end

    // Reset in the middle of operation with a write pending.
    wr_valid = 1'b1; wr_data = 32'h1234_5678; wr_last = 1'b0; rd_release = 1'b0; flush = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("midrst", 1'b1, 1'b0, 4'h0, 2'd0, z);
    rst = 1'b0;

    // Stream a tile, then wait a bounded time for it to be presented.
    for (int r = 0; r < NR; r++) begin
      wr_valid = 1'b1; wr_data = q(8'h90, r);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    k = 0;
    while (!rd_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("stream_timeout", 128'(rd_valid), 128'(1'b1));
    check_all("stream", 1'b1, 1'b1, 4'hF, 2'd1, full4(8'h90));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
